bpm_digit_sequencer: RTL
========================

# bpm_digit_sequencer

Sequences the existing `display_sprite_map` lookup to render a three-digit heart-rate value. On `start`, it splits a binary BPM value into hundreds, tens and ones digits by repeated subtraction. It then drives one digit at a time into the sprite map and captures the returned sprite-sheet rectangle. All three rectangles are committed atomically to the pixel renderer, together with leading-zero blank flags.

## Interface
Parameters:
- `SAT_VALUE`, 999: inputs above this are clamped to it.
- `COORD_W`, 11: width of one sprite coordinate.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to convert `value`; ignored while `busy`=1.
- `value`  in  10: binary BPM, sampled only on an accepted `start`.
- `busy`  out  1: high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1: one-cycle pulse; the new rectangles are visible in the same cycle.
- `sm_number`  out  4: digit driven to `display_sprite_map.number`; registered.
- `sm_x_left`, `sm_x_right`, `sm_y_top`, `sm_y_bottom`  in  `COORD_W` each: returned rectangle from `display_sprite_map`, one-cycle registered latency.
- `rects`  out  12*`COORD_W` (132): packed committed rectangles.
  - Digit d (2 = hundreds, 1 = tens, 0 = ones) occupies bits [44d+43:44d].
  - Within a digit, fields from MSB to LSB: x_left, x_right, y_top, y_bottom.
- `digit_blank`  out  3: leading-zero suppression, committed with `rects`.

## Operation
- States:
  - IDLE
  - CONV_H (hundreds)
  - CONV_T (tens)
  - LOOK (drive `sm_number`)
  - CAPT (capture sprite outputs)
  - DONE
- IDLE + `start`:
  - rem ← min(`value`, `SAT_VALUE`); h ← 0; t ← 0; digit index ← 2.
  - Go to CONV_H.
- CONV_H:
  - If rem ≥ 100: rem ← rem − 100 and h ← h + 1; stay.
  - Else go to CONV_T.
- CONV_T:
  - If rem ≥ 10: rem ← rem − 10 and t ← t + 1; stay.
  - Else ones ← rem[3:0]; `sm_number` ← h; go to LOOK.
- LOOK: go to CAPT. The sprite map samples `sm_number` on this edge.
- CAPT:
  - Shadow[index] ← the four `sm_*` inputs.
  - If index > 0: index ← index − 1; `sm_number` ← next digit (t, then ones); go to LOOK.
  - Else go to DONE.
- DONE:
  - `rects` ← shadow.
  - `digit_blank` ← {h==0, h==0 && t==0, 0}.
  - `done` = 1; go to IDLE.
- Blanked digits are still looked up. Their rectangles are valid, and the renderer masks them.
- `rects` and `digit_blank` change only at the DONE commit. The renderer never sees a partial update.
- `start` during `busy` is dropped, not queued.
- Reset mid-operation:
  - Next cycle: IDLE.
  - Shadow registers and committed outputs are cleared.
  - No `done` is emitted.

## Timing
- Reset values: `busy`=0, `done`=0, `sm_number`=0, `rects`=0, `digit_blank`=3'b000, state=IDLE.
- Let E0 be the edge that accepts `start`. Edge counts from E0:
  - CONV_H occupies h+1 cycles.
  - CONV_T occupies t+1 cycles.
  - LOOK/CAPT occupies 6 cycles.
- `done` is high in cycle h+t+8 after E0:
  - value 0: cycle 8.
  - value 72: cycle 15.
  - value ≥ 999: cycle 26.
- `busy` drops in the cycle after `done`. A new `start` is accepted in that cycle, so back-to-back throughput is h+t+9 cycles per update.
- Arithmetic:
  - rem is 10 bits, unsigned.
  - h and t are 4 bits and never exceed 9 after clamping.
  - No wrap is possible.

## Structure
Shared package `heartaware_pkg` holds:
- The state enumeration.
- `COORD_W`.
- `SAT_VALUE`.
- Digit index constants `DIG_H`=2, `DIG_T`=1, `DIG_O`=0.
- The per-digit rectangle field offsets within `rects`.

Sub-modules:
- Natural sub-module: `bpm_bcd_split`. It contains the CONV_H/CONV_T subtractor and has a start/done handshake.
- `display_sprite_map` is instantiated by the parent. It is not inside this block.

## Test plan
- Reset, then `value`=72 → `done` at cycle 15.
  - Hundreds rect = 567/608/281/355.
  - Tens rect = 419/464/281/355.
  - Ones rect = 172/222/281/355.
  - `digit_blank`=3'b100.
- `value`=0 → `done` at cycle 8; all three rects = 567/608/281/355; `digit_blank`=3'b110.
- `value`=1023 → clamped to 999; `done` at cycle 26; every rect = 515/567/281/355; `digit_blank`=0.
- `value`=105, with a second `start` (`value`=42) pulsed at cycle 3:
  - The second request is ignored.
  - Only one `done`.
  - Digits 1/0/5; `digit_blank`=0.
- Complete 72, then start 105 and assert `reset` at cycle 10:
  - No `done`.
  - `rects`=0 and `busy`=0 in the cycle after reset.
  - A fresh `start` with 60 completes normally.
- Two back-to-back requests, 88 then 120:
  - `rects` holds the 88 values, unchanged, until the second `done`.
  - No mixed digits are observed on any cycle.

Source files
------------

// File: rtl/heartaware_pkg.sv
// Shared types and constants for the heart-rate digit display path.
// Rectangle layout: digit d at rect_lsb(d); fields x_left, x_right, y_top, y_bottom from MSB down.
package heartaware_pkg;

  localparam int COORD_W    = 11;
  localparam int SAT_VALUE  = 999;
  localparam int VALUE_W    = 10;
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;

  localparam int DIG_H = 2;
  localparam int DIG_T = 1;
  localparam int DIG_O = 0;

  // Field slots inside one digit rectangle, in units of one coordinate.
  localparam int FLD_XL = 3;
  localparam int FLD_XR = 2;
  localparam int FLD_YT = 1;
  localparam int FLD_YB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_H,
    ST_CONV_T,
    ST_LOOK,
    ST_CAPT,
    ST_DONE
  } seq_state_e;

  function automatic int rect_lsb(input int digit, input int coord_w);
    return digit * 4 * coord_w;
  endfunction

  function automatic int field_lsb(input int digit, input int field, input int coord_w);
    return rect_lsb(digit, coord_w) + field * coord_w;
  endfunction

endpackage

// File: rtl/bpm_digit_sequencer_if.sv
// Request/result bus between the BPM producer and the digit sequencer.
// master drives start/value; slave returns busy/done and the committed rectangles.
interface bpm_digit_sequencer_if #(
  parameter int COORD_W = heartaware_pkg::COORD_W
);
  logic                   start;
  logic [9:0]             value;
  logic                   busy;
  logic                   done;
  logic [12*COORD_W-1:0]  rects;
  logic [2:0]             digit_blank;

  modport master (
    output start, value,
    input  busy, done, rects, digit_blank
  );

  modport slave (
    input  start, value,
    output busy, done, rects, digit_blank
  );
endinterface

// File: rtl/bpm_bcd_split.sv
// Clamps a binary BPM value and splits it into hundreds/tens/ones by repeated subtraction.
// done_o is asserted during the final tens cycle so the caller can take the digits on that edge.
module bpm_bcd_split
  import heartaware_pkg::*;
#(
  parameter int SAT = heartaware_pkg::SAT_VALUE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               done_o,
  output logic [DIGIT_W-1:0] hund_o,
  output logic [DIGIT_W-1:0] tens_o,
  output logic [DIGIT_W-1:0] ones_o
);

  seq_state_e         state_q;
  logic [VALUE_W-1:0] rem_q;
  logic [DIGIT_W-1:0] h_q;
  logic [DIGIT_W-1:0] t_q;
  logic [VALUE_W-1:0] clamped_d;

  assign clamped_d = (value_i > VALUE_W'(SAT)) ? VALUE_W'(SAT) : value_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      h_q     <= '0;
      t_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            rem_q   <= clamped_d;
            h_q     <= '0;
            t_q     <= '0;
            state_q <= ST_CONV_H;
          end
        end
        ST_CONV_H: begin
          if (rem_q >= VALUE_W'(100)) begin
            rem_q <= rem_q - VALUE_W'(100);
            h_q   <= h_q + DIGIT_W'(1);
          end else begin
            state_q <= ST_CONV_T;
          end
        end
        ST_CONV_T: begin
          if (rem_q >= VALUE_W'(10)) begin
            rem_q <= rem_q - VALUE_W'(10);
            t_q   <= t_q + DIGIT_W'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done_o = (state_q == ST_CONV_T) && (rem_q < VALUE_W'(10));
  assign hund_o = h_q;
  assign tens_o = t_q;
  assign ones_o = rem_q[DIGIT_W-1:0];

endmodule

// File: rtl/bpm_digit_sequencer.sv
// Converts a BPM value to three digits, looks each up in the external sprite map,
// and commits all three rectangles plus leading-zero blanks in one cycle.
module bpm_digit_sequencer #(
  parameter int SAT_VALUE = heartaware_pkg::SAT_VALUE,
  parameter int COORD_W   = heartaware_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               reset,
  bpm_digit_sequencer_if.slave bus,
  output logic [3:0]         sm_number,
  input  logic [COORD_W-1:0] sm_x_left,
  input  logic [COORD_W-1:0] sm_x_right,
  input  logic [COORD_W-1:0] sm_y_top,
  input  logic [COORD_W-1:0] sm_y_bottom
);
  import heartaware_pkg::*;

  localparam int RW = 4 * COORD_W;

  seq_state_e                state_q;
  logic [1:0]                idx_q;
  logic [DIGIT_W-1:0]        h_q;
  logic [DIGIT_W-1:0]        t_q;
  logic [DIGIT_W-1:0]        o_q;
  logic [RW-1:0]             shadow_q [NUM_DIGITS];
  logic                      busy_q;
  logic                      done_q;
  logic [DIGIT_W-1:0]        sm_number_q;
  logic [NUM_DIGITS*RW-1:0]  rects_q;
  logic [2:0]                blank_q;

  logic                      accept_d;
  logic [RW-1:0]             sprite_rect_d;
  logic [NUM_DIGITS*RW-1:0]  commit_d;
  logic                      split_done;
  logic [DIGIT_W-1:0]        split_h;
  logic [DIGIT_W-1:0]        split_t;
  logic [DIGIT_W-1:0]        split_o;

  assign accept_d = (state_q == ST_IDLE) && bus.start;

  assign sprite_rect_d[FLD_XL*COORD_W +: COORD_W] = sm_x_left;
  assign sprite_rect_d[FLD_XR*COORD_W +: COORD_W] = sm_x_right;
  assign sprite_rect_d[FLD_YT*COORD_W +: COORD_W] = sm_y_top;
  assign sprite_rect_d[FLD_YB*COORD_W +: COORD_W] = sm_y_bottom;

  // The ones rectangle arrives on the commit edge itself, so it bypasses the shadow.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_commit
      if (gi == DIG_O) begin : g_live
        assign commit_d[rect_lsb(gi, COORD_W) +: RW] = sprite_rect_d;
      end else begin : g_shadow
        assign commit_d[rect_lsb(gi, COORD_W) +: RW] = shadow_q[gi];
      end
    end
  endgenerate

  bpm_bcd_split #(
    .SAT(SAT_VALUE)
  ) u_split (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept_d),
    .value_i (bus.value),
    .done_o  (split_done),
    .hund_o  (split_h),
    .tens_o  (split_t),
    .ones_o  (split_o)
  );

  // ST_CONV_H covers the whole split; the splitter walks hundreds then tens internally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'(DIG_H);
      h_q         <= '0;
      t_q         <= '0;
      o_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sm_number_q <= '0;
      rects_q     <= '0;
      blank_q     <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shadow_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            busy_q  <= 1'b1;
            idx_q   <= 2'(DIG_H);
            state_q <= ST_CONV_H;
          end
        end
        ST_CONV_H, ST_CONV_T: begin
          if (split_done) begin
            h_q         <= split_h;
            t_q         <= split_t;
            o_q         <= split_o;
            sm_number_q <= split_h;
            state_q     <= ST_LOOK;
          end
        end
        ST_LOOK: state_q <= ST_CAPT;
        ST_CAPT: begin
          shadow_q[idx_q] <= sprite_rect_d;
          if (idx_q != 2'(DIG_O)) begin
            idx_q       <= idx_q - 2'd1;
            sm_number_q <= (idx_q == 2'(DIG_H)) ? t_q : o_q;
            state_q     <= ST_LOOK;
          end else begin
            rects_q <= commit_d;
            blank_q <= {h_q == '0, (h_q == '0) && (t_q == '0), 1'b0};
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rects       = rects_q;
  assign bus.digit_blank = blank_q;
  assign sm_number       = sm_number_q;

endmodule
